// File: rtl/piece_queue_controller_pkg.sv
// Shared tetromino types: block index width, state encoding and the index sanitizer
// used wherever a generator value enters the piece bookkeeping.
package tetris_pkg;

  localparam int BLOCK_W    = 3;
  localparam int NUM_BLOCKS = 7;
  localparam int CNT_W      = 3;

  typedef logic [BLOCK_W-1:0] block_idx_t;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    CAPT  = 2'd1,
    READY = 2'd2
  } ctrl_state_t;

  // Out-of-range generator codes (7) become piece 0 so no illegal index is stored.
  function automatic block_idx_t sanitize_idx(input block_idx_t idx);
    return (idx >= block_idx_t'(NUM_BLOCKS)) ? '0 : idx;
  endfunction

endpackage

// File: rtl/piece_queue_controller_if.sv
// Request/generator/status bundle between the piece queue controller and the game side.
// The controller uses the slave view; the game FSM and generator use the master view.
interface piece_queue_controller_if #(
  parameter int QUEUE_DEPTH = 3,
  parameter int BLOCK_W     = 3
);

  logic                           spawn_req;
  logic                           hold_req;
  logic [BLOCK_W-1:0]             gen_block_idx;
  logic                           gen_new_block;
  logic                           ready;
  logic [BLOCK_W-1:0]             active_idx;
  logic                           active_valid;
  logic [BLOCK_W-1:0]             hold_idx;
  logic                           hold_valid;
  logic                           hold_used;
  logic [QUEUE_DEPTH*BLOCK_W-1:0] preview_idx;

  modport master (
    output spawn_req, hold_req, gen_block_idx,
    input  gen_new_block, ready, active_idx, active_valid,
           hold_idx, hold_valid, hold_used, preview_idx
  );

  modport slave (
    input  spawn_req, hold_req, gen_block_idx,
    output gen_new_block, ready, active_idx, active_valid,
           hold_idx, hold_valid, hold_used, preview_idx
  );

endinterface

// File: rtl/piece_queue_controller_piece_fifo.sv
// Shift-register preview queue: push writes the first free slot, pop shifts toward the head.
// The owner never pushes and pops in the same cycle.
module piece_fifo #(
  parameter int DEPTH   = 3,
  parameter int BLOCK_W = 3,
  parameter int CNT_W   = 3
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [BLOCK_W-1:0]       push_idx,
  output logic [BLOCK_W-1:0]       head_idx,
  output logic [CNT_W-1:0]         count,
  output logic [DEPTH*BLOCK_W-1:0] slots
);

  logic [BLOCK_W-1:0] q [DEPTH];
  logic [CNT_W-1:0]   cnt;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else if (push) begin
      for (int i = 0; i < DEPTH; i++)
        if (cnt == CNT_W'(i)) q[i] <= push_idx;
      cnt <= cnt + CNT_W'(1);
    end else if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) q[i] <= q[i+1];
      q[DEPTH-1] <= '0;
      cnt        <= cnt - CNT_W'(1);
    end
  end

  assign head_idx = q[0];
  assign count    = cnt;

  for (genvar g = 0; g < DEPTH; g++) begin : g_slots
    assign slots[g*BLOCK_W +: BLOCK_W] = q[g];
  end

endmodule

// File: rtl/piece_queue_controller.sv
// Refills the preview queue from the tetromino generator and serves spawn/hold requests,
// owning the active piece and the hold slot.
module piece_queue_controller #(
  parameter int QUEUE_DEPTH = 3,
  parameter int BLOCK_W     = 3
) (
  input  logic                     Clk,
  input  logic                     Reset,
  piece_queue_controller_if.slave  bus
);

  import tetris_pkg::*;

  ctrl_state_t        state, state_n;
  logic [BLOCK_W-1:0] active_q, hold_q, head_idx, capt_idx;
  logic               active_vld, hold_vld, hold_used_q;
  logic               push, pop, do_spawn, do_hold;
  logic [CNT_W-1:0]   count;

  assign capt_idx = sanitize_idx(bus.gen_block_idx);

  piece_fifo #(
    .DEPTH   (QUEUE_DEPTH),
    .BLOCK_W (BLOCK_W),
    .CNT_W   (CNT_W)
  ) u_fifo (
    .Clk      (Clk),
    .Reset    (Reset),
    .push     (push),
    .pop      (pop),
    .push_idx (capt_idx),
    .head_idx (head_idx),
    .count    (count),
    .slots    (bus.preview_idx)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) state <= FILL;
    else        state <= state_n;
  end

  // Requests only count in READY; spawn has priority over hold.
  always_comb begin
    state_n  = state;
    push     = 1'b0;
    pop      = 1'b0;
    do_spawn = 1'b0;
    do_hold  = 1'b0;
    case (state)
      FILL: state_n = CAPT;
      CAPT: begin
        push    = 1'b1;
        state_n = (count + CNT_W'(1) == CNT_W'(QUEUE_DEPTH)) ? READY : FILL;
      end
      READY: begin
        if (bus.spawn_req) begin
          do_spawn = 1'b1;
          pop      = 1'b1;
          state_n  = FILL;
        end else if (bus.hold_req && active_vld && !hold_used_q) begin
          do_hold = 1'b1;
          if (!hold_vld) begin
            pop     = 1'b1;
            state_n = FILL;
          end
        end
      end
      default: state_n = FILL;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      active_q    <= '0;
      active_vld  <= 1'b0;
      hold_q      <= '0;
      hold_vld    <= 1'b0;
      hold_used_q <= 1'b0;
    end else if (do_spawn) begin
      active_q    <= head_idx;
      active_vld  <= 1'b1;
      hold_used_q <= 1'b0;
    end else if (do_hold) begin
      hold_q      <= active_q;
      hold_vld    <= 1'b1;
      hold_used_q <= 1'b1;
      // An empty hold slot pulls the next piece from the queue instead of swapping.
      active_q    <= hold_vld ? hold_q : head_idx;
    end
  end

  assign bus.gen_new_block = Reset && (state == FILL);
  assign bus.ready         = (state == READY);
  assign bus.active_idx    = active_q;
  assign bus.active_valid  = active_vld;
  assign bus.hold_idx      = hold_q;
  assign bus.hold_valid    = hold_vld;
  assign bus.hold_used     = hold_used_q;

endmodule

// File: doc/piece_queue_controller.md
Name: piece_queue_controller

Overview:
- Sequences the tetromino generator and owns all piece bookkeeping between the generator and the game FSM.
- Keeps a preview queue of upcoming pieces plus the active piece and a hold slot.
- Issues single-cycle new_block pulses to the generator whenever the queue has room, and captures the returned index.
- Serves spawn and hold requests from the game logic through a ready-gated request interface.

Parameters:
- QUEUE_DEPTH, 3, number of preview slots (legal 1..6).
- BLOCK_W, 3, width of a block index.

Ports:
- Clk  input  1  system clock.
- Reset  input  1  synchronous, active-low reset (Reset==0 resets on the Clk edge).
- spawn_req  input  1  pulse: pop queue head into the active piece.
- hold_req  input  1  pulse: hold or swap the active piece.
- gen_block_idx  input  BLOCK_W  current index from the generator, valid the cycle after gen_new_block.
- gen_new_block  output  1  one-cycle request to the generator for a new index.
- ready  output  1  controller accepts spawn_req/hold_req this cycle.
- active_idx  output  BLOCK_W  current falling piece.
- active_valid  output  1  active_idx is meaningful.
- hold_idx  output  BLOCK_W  held piece.
- hold_valid  output  1  hold slot occupied.
- hold_used  output  1  hold already used for the current active piece.
- preview_idx  output  QUEUE_DEPTH*BLOCK_W  queue contents; slot 0 (head) in the LSBs.

Behaviour:
- Reset values while Reset==0:
  - all outputs 0; queue slots 0; count=0; state=FILL.
  - Reset asserted mid-operation aborts any state on that edge; a captured index is discarded.
- States:
  - FILL: gen_new_block=1 for exactly this cycle; next state CAPT.
  - CAPT: sanitize gen_block_idx, where value 7 maps to 0 and 0..6 pass through. Write it to queue[count]; count+=1. If count+1==QUEUE_DEPTH go to READY, else FILL.
  - READY: ready=1; this is the only state where requests are sampled. Requests in other states are ignored (dropped, not queued).
- Actions in READY:
  - spawn_req:
    - active_idx<=queue[0], active_valid<=1, hold_used<=0.
    - queue[i]<=queue[i+1]; the top slot is zeroed; count-=1.
    - Go to FILL.
  - hold_req, with active_valid=1, hold_used=0 and hold_valid=1:
    - swap active_idx and hold_idx; hold_used<=1.
    - Stay in READY; completes in one cycle.
  - hold_req, with active_valid=1, hold_used=0 and hold_valid=0:
    - hold_idx<=active_idx, hold_valid<=1, hold_used<=1.
    - active_idx<=queue[0]; shift as for spawn; go to FILL.
  - hold_req with active_valid=0 or hold_used=1: ignored, no state change.
  - spawn_req and hold_req in the same cycle: spawn wins and hold is dropped.
- Latency:
  - After Reset goes high, ready rises 2*QUEUE_DEPTH cycles later. With the default depth: pulses on cycles 0, 2, 4 after release; ready on cycle 6.
  - Spawn accepted at edge t: active_idx is updated at t+1, gen_new_block is high at t+1, capture at t+2, ready at t+3.
- Width rules: count is 3 bits and saturates logically at QUEUE_DEPTH; FILL is never entered with count==QUEUE_DEPTH.
- gen_new_block is never high for two consecutive cycles; the generator is given one full cycle to update.
- The queue never holds the value 7. Neither active_idx nor hold_idx is ever 7.

Decomposition:
- Shared package tetris_pkg:
  - BLOCK_W.
  - NUM_BLOCKS=7.
  - block_idx_t typedef.
  - ctrl state enum {FILL, CAPT, READY}.
  - function sanitize_idx().
- One natural sub-module: piece_fifo. A shift-register queue with push, pop and count; simultaneous push and pop is illegal, and the controller guarantees this.
- The FSM and the hold logic remain in piece_queue_controller.

Test Plan:
1. Reset fill: Reset low 2 cycles then high. The bench model answers gen_block_idx 2, 5, 7.
   - Required: gen_new_block pulses on cycles 0, 2, 4.
   - ready=1 at cycle 6; preview_idx = {0, 5, 2}, with 7 sanitized to 0.
2. Spawn: from the filled queue {0, 5, 2}, pulse spawn_req; the model answers 4.
   - Required: active_idx=2 and active_valid=1 next cycle; gen_new_block one pulse.
   - ready back 3 cycles after acceptance; preview_idx = {4, 0, 5}.
3. Hold into empty slot: active=2, queue {4, 0, 5}, hold_req; the model answers 6.
   - Required: hold_idx=2, hold_valid=1, active_idx=5, hold_used=1; preview = {6, 4, 0}.
   - A second hold_req is ignored.
4. Swap hold: spawn (active=0, hold_used clears), then hold_req.
   - Required: active_idx=2, hold_idx=0 in one cycle; ready stays 1; no gen_new_block.
5. Collisions: spawn_req and hold_req together in READY.
   - Required: only the spawn is performed.
   - spawn_req while in FILL or CAPT is dropped: active_idx unchanged.
6. Mid-refill reset: Reset low during CAPT.
   - Required: all outputs 0 next edge.
   - Refill restarts with three fresh pulses after release.
